// File: rtl/parity_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parity_pkg: shared state encoding and parity constants           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/parity_frame_serializer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parity_frame_serializer_if: word handshake and serial stream     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface parity_frame_serializer_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              out;
  logic              frame;
  logic              last;
  logic              busy;

  modport master (
    output data_in, valid,
    input  ready, out, frame, last, busy
  );

  modport slave (
    input  data_in, valid,
    output ready, out, frame, last, busy
  );

endinterface
`default_nettype wire

// File: rtl/parity_frame_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parity_frame_serializer: word in, LSB-first bits + parity + gap  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module parity_frame_serializer
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PARITY_ODD = int'(PARITY_EVEN),
  parameter int IDLE_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  parity_frame_serializer_if.slave  bus
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_CNT_W = (IDLE_BITS > 0) ? $clog2(IDLE_BITS + 1) : 1;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
  localparam logic                 ODD_BIT  = 1'(PARITY_ODD);

  state_t                state, state_n;
  logic [DATA_W-1:0]     shreg, shreg_n;
  logic                  par_bit, par_bit_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [GAP_CNT_W-1:0]  gap_cnt, gap_cnt_n;
  logic                  ready_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // ready is the only output that looks at rst directly, so no word is taken during reset
  assign ready_w = (state == ST_IDLE) && !rst;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.valid && ready_w) begin
          shreg_n   = bus.data_in;
          par_bit_n = (^bus.data_in) ^ ODD_BIT;
          bit_cnt_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        gap_cnt_n = '0;
        state_n   = (IDLE_BITS > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == LAST_GAP) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = ready_w;
    bus.out   = 1'b0;
    bus.frame = 1'b0;
    bus.last  = 1'b0;
    bus.busy  = (state != ST_IDLE);
    case (state)
      ST_DATA: begin
        bus.out   = shreg[0];
        bus.frame = 1'b1;
      end
      ST_PARITY: begin
        bus.out   = par_bit;
        bus.frame = 1'b1;
        bus.last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_parity_frame_serializer: three configurations vs frame model  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_parity_frame_serializer;
  import parity_pkg::*;

  localparam int W = DEFAULT_DATA_W;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         v [N];
  logic [W-1:0] d [N];
  logic [4:0]   obs [N];

  parity_frame_serializer_if #(.DATA_W(W)) bus0 ();
  parity_frame_serializer_if #(.DATA_W(W)) bus1 ();
  parity_frame_serializer_if #(.DATA_W(W)) bus2 ();

  assign bus0.valid = v[0];
  assign bus0.data_in = d[0];
  assign bus1.valid = v[1];
  assign bus1.data_in = d[1];
  assign bus2.valid = v[2];
  assign bus2.data_in = d[2];
  assign obs[0] = {bus0.ready, bus0.busy, bus0.frame, bus0.last, bus0.out};
  assign obs[1] = {bus1.ready, bus1.busy, bus1.frame, bus1.last, bus1.out};
  assign obs[2] = {bus2.ready, bus2.busy, bus2.frame, bus2.last, bus2.out};

  parity_frame_serializer #(.DATA_W(W), .PARITY_ODD(0), .IDLE_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  parity_frame_serializer #(.DATA_W(W), .PARITY_ODD(1), .IDLE_BITS(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  parity_frame_serializer #(.DATA_W(W), .PARITY_ODD(0), .IDLE_BITS(3))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  function automatic logic odd_of(int i);
    return (i == 1);
  endfunction

  function automatic int gap_of(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Pending frame per DUT: entries are {out, frame, last}, entry pos is on the wire now
  logic [2:0] seq [N][0:15];
  int         len [N];
  int         pos [N];
  bit         acc [N];
  logic       fx  [N];
  int         checks = 0;
  int         errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] w);
    for (int b = 0; b < W; b++) seq[i][b] = {w[b], 1'b1, 1'b0};
    seq[i][W] = {(^w) ^ odd_of(i), 1'b1, 1'b1};
    for (int g = 0; g < gap_of(i); g++) seq[i][W+1+g] = 3'b000;
    len[i] = W + 1 + gap_of(i);
    pos[i] = 0;
  endtask

  task automatic tick();
    logic [4:0] e;
    logic [2:0] s;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        len[i] = 0;
        pos[i] = 0;
        fx[i]  = 1'b0;
      end else if (pos[i] == len[i]) begin
        if (v[i]) begin
          acc[i] = 1'b1;
          push(i, d[i]);
        end
      end else begin
        pos[i]++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (pos[i] < len[i]) begin
        s = seq[i][pos[i]];
        e = {1'b0, 1'b1, s[1], s[0], s[2]};
      end else begin
        e = {!rst, 4'b0000};
      end
      check_val($sformatf("dut%0d_rdy_bsy_frm_lst_out", i), 32'(obs[i]), 32'(e));
      // downstream checker: ones in data+parity must match the parity sense
      if (obs[i][1]) begin
        check_val($sformatf("dut%0d_chain_state", i), 32'(fx[i] ^ obs[i][0]), 32'(odd_of(i)));
        fx[i] = 1'b0;
      end else if (obs[i][2]) begin
        fx[i] = fx[i] ^ obs[i][0];
      end
    end
  endtask

  task automatic send(input int i, input logic [W-1:0] w, output int n);
    v[i]   = 1'b1;
    d[i]   = w;
    acc[i] = 1'b0;
    n      = 0;
    while (!acc[i] && n < 40) begin
      tick();
      n++;
    end
    if (!acc[i]) check_val($sformatf("dut%0d_accept_timeout", i), 32'(n), 32'(0));
    v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (pos[i] != len[i] && n < 40) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; d[i] = '0; len[i] = 0; pos[i] = 0; fx[i] = 1'b0; acc[i] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    send(0, 8'hA5, n); wait_idle(0);
    send(0, 8'h07, n); wait_idle(0);
    send(1, 8'h00, n); wait_idle(1);
    send(2, 8'h5A, n); wait_idle(2);
    // valid held high across two words
    send(0, 8'hFF, n); send(0, 8'h01, n); wait_idle(0);
    send(1, 8'hFF, n); send(1, 8'h01, n); wait_idle(1);

    // reset during bit 3, then a word must be taken on the very next edge
    send(0, 8'hFF, n);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(0, 8'h3C, n);
    check_val("accept_first_edge_after_rst", 32'(n), 32'(1));
    wait_idle(0);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !v[i]) begin
          v[i] = ($urandom_range(2) != 0);
          d[i] = W'($urandom);
        end
      end
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
